// File: rtl/jtag_scan_master.sv
// jtag_scan_master
// Command-driven JTAG master. Turns {op, len, data} commands into complete
// TLR walks, IR scans or DR scans that start and end in Run-Test/Idle, and
// collects the TDO stream of the shift phase.
//
// Ports:
//   TCK, TRST_N          scan clock (rising edge) and async active-low reset
//   cmd_valid/cmd_ready  command handshake; accepted when both are high
//   cmd_op               00 TLR walk, 01 IR scan, 10 DR scan, 11 NOP
//   cmd_len              scan length, clamped to 1..MAX_LEN
//   cmd_data             TDI bits, shifted LSB first
//   rsp_valid            one-cycle pulse on command completion
//   rsp_data             captured TDO bits, right-justified
//   busy                 high whenever the master is not idle
//   TMS, TDI             registered outputs to the target TAP
//   TDO                  serial data from the target
module jtag_scan_master #(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               TCK,
  input  logic               TRST_N,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  // Each state names the TMS value currently held on the output register.
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_TLR, S_PRE, S_SHIFT, S_EXIT, S_UPD, S_NOP
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               is_ir_q, is_ir_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] tx_q, tx_d;    // remaining TDI bits, LSB next
  logic [MAX_LEN-1:0] rx_q, rx_d;    // captured TDO bits
  logic [MAX_LEN-1:0] bit_q, bit_d;  // one-hot capture position

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0) return LEN_W'(1);
    else if (l > LEN_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    else return l;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_ir_d     = is_ir_q;
    len_d       = len_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    tms_d       = 1'b0;
    tdi_d       = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == LEN_W'(5)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = '0;
          len_d   = clamp_len(cmd_len);
          tx_d    = cmd_data;
          rx_d    = '0;
          bit_d   = MAX_LEN'(1);
          is_ir_d = (cmd_op == 2'b01);
          case (cmd_op)
            2'b00:   state_d = S_TLR;
            2'b11:   state_d = S_NOP;
            default: state_d = S_PRE;
          endcase
        end
      end
      S_TLR: begin
        if (cnt_q == LEN_W'(5)) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_PRE: begin
        // IR needs one extra Select step before Capture/Shift.
        if (cnt_q == (is_ir_q ? LEN_W'(3) : LEN_W'(2))) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_SHIFT: begin
        // The edge ending a shift cycle samples TDO for that bit.
        if (TDO) rx_d = rx_q | bit_q;
        bit_d = bit_q << 1;
        if (cnt_q == len_q - LEN_W'(1)) begin
          state_d = S_EXIT;
        end else begin
          cnt_d = cnt_q + LEN_W'(1);
        end
      end
      S_EXIT: state_d = S_UPD;
      S_UPD: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_q;
      end
      S_NOP: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_data_d  = '0;
      end
      default: state_d = S_INIT;
    endcase

    // Output decode from the next state so TMS/TDI come straight from flops.
    case (state_d)
      S_INIT, S_TLR: tms_d = (cnt_d < LEN_W'(5));
      S_PRE:         tms_d = is_ir_d ? (cnt_d < LEN_W'(2)) : (cnt_d == '0);
      S_SHIFT: begin
        tms_d = (cnt_d == len_d - LEN_W'(1));
        tdi_d = tx_q[0];
        tx_d  = tx_q >> 1;
      end
      S_EXIT:        tms_d = 1'b1;
      default:       tms_d = 1'b0;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      is_ir_q     <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_ir_q     <= is_ir_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Scan datapath; always reloaded on acceptance, so no reset needed.
  always_ff @(posedge TCK) begin
    len_q <= len_d;
    tx_q  <= tx_d;
    rx_q  <= rx_d;
    bit_q <= bit_d;
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
module tb_jtag_scan_master;
  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic               TCK = 1'b0;
  logic               TRST_N = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               TMS;
  logic               TDI;
  logic               TDO;
  logic               tdo_r = 1'b0;

  int checks = 0;
  int failures = 0;

  jtag_scan_master #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .TCK(TCK), .TRST_N(TRST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .TMS(TMS), .TDI(TDI), .TDO(TDO)
  );

  always #5 TCK = ~TCK;

  // Target stand-in: TDO is TDI delayed by one register.
  always @(posedge TCK) tdo_r <= TDI;
  assign TDO = tdo_r;

  typedef struct {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic [31:0]      data;
    int               len_eff;
    int               n;
    logic [31:0]      rsp;
    string            name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic tms_exp(input logic [1:0] op, input int len, input int k);
    case (op)
      2'b00: return (k < 5);
      2'b01: begin
        if (k < 2) return 1'b1;
        if (k < 4) return 1'b0;
        if (k < 4 + len) return (k == 3 + len);
        return (k == 4 + len);
      end
      2'b10: begin
        if (k == 0) return 1'b1;
        if (k < 3) return 1'b0;
        if (k < 3 + len) return (k == 2 + len);
        return (k == 3 + len);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic tdi_exp(input logic [1:0] op, input int len,
                                   input logic [31:0] data, input int k);
    int s;
    s = (op == 2'b01) ? 4 : 3;
    if (op == 2'b00 || op == 2'b11) return 1'b0;
    if (k >= s && k < s + len) return data[k - s];
    return 1'b0;
  endfunction

  // Called #1 after an edge with the master idle; returns #1 after the
  // completion edge, i.e. inside the rsp_valid cycle.
  task automatic run_cmd(input string name, input logic [1:0] op,
                         input logic [LEN_W-1:0] len, input logic [31:0] data,
                         input int len_eff, input int n, input logic [31:0] exp_rsp,
                         input bit noise);
    check($sformatf("%s ready", name), cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s tms k=%0d", name, k), TMS, tms_exp(op, len_eff, k));
      check($sformatf("%s tdi k=%0d", name, k), TDI, tdi_exp(op, len_eff, data, k));
      check($sformatf("%s busy/ready/rsp k=%0d", name, k),
            {busy, cmd_ready, rsp_valid}, 3'b100);
      if (noise) begin
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_len   = LEN_W'($urandom);
        cmd_data  = $urandom;
      end
      @(posedge TCK); #1;
    end
    cmd_valid = 1'b0;
    check($sformatf("%s rsp_valid", name), rsp_valid, 1);
    check($sformatf("%s rsp_data", name), rsp_data, exp_rsp);
    check($sformatf("%s done busy/ready/tms", name), {busy, cmd_ready, TMS}, 3'b010);
  endtask

  // Called while TRST_N is low, away from a clock edge.
  task automatic init_walk(input string name);
    TRST_N = 1'b1;
    check($sformatf("%s tms c=0", name), TMS, 1);
    for (int c = 1; c <= 5; c++) begin
      @(posedge TCK); #1;
      check($sformatf("%s tms c=%0d", name, c), TMS, (c < 5) ? 1 : 0);
      check($sformatf("%s busy/ready/rsp c=%0d", name, c),
            {busy, cmd_ready, rsp_valid}, 3'b100);
    end
    @(posedge TCK); #1;
    check($sformatf("%s idle tms", name), TMS, 0);
    check($sformatf("%s idle busy/ready/rsp", name), {busy, cmd_ready, rsp_valid}, 3'b010);
  endtask

  initial begin
    vecs[0] = '{2'b01, 6'd5,  32'h0000_0000, 5,  11, 32'h0000_0000, "ir5_zero"};
    vecs[1] = '{2'b10, 6'd8,  32'h0000_00A5, 8,  13, 32'h0000_004A, "dr8_a5"};
    vecs[2] = '{2'b00, 6'd9,  32'hFFFF_FFFF, 0,  6,  32'h0000_0000, "tlr"};
    vecs[3] = '{2'b11, 6'd7,  32'hFFFF_FFFF, 0,  1,  32'h0000_0000, "nop"};
    vecs[4] = '{2'b01, 6'd3,  32'h0000_0005, 3,  9,  32'h0000_0002, "ir3_101"};
    vecs[5] = '{2'b10, 6'd32, 32'h8000_0001, 32, 37, 32'h0000_0002, "dr32"};
    vecs[6] = '{2'b10, 6'd63, 32'hFFFF_FFFF, 32, 37, 32'hFFFF_FFFE, "dr63_clamp"};

    // Reset state
    repeat (2) @(posedge TCK);
    #1;
    check("reset tms/tdi", {TMS, TDI}, 2'b10);
    check("reset busy/ready/rsp", {busy, cmd_ready, rsp_valid}, 3'b100);
    check("reset rsp_data", rsp_data, 0);

    init_walk("init");
    @(posedge TCK); #1;
    check("idle hold", {busy, cmd_ready, TMS, TDI, rsp_valid}, 5'b01000);

    for (int i = 0; i < 7; i++) begin
      run_cmd(vecs[i].name, vecs[i].op, vecs[i].len, vecs[i].data,
              vecs[i].len_eff, vecs[i].n, vecs[i].rsp, 1'b0);
      @(posedge TCK); #1;
      check($sformatf("%s rsp_valid drop", vecs[i].name), rsp_valid, 0);
      check($sformatf("%s rsp_data hold", vecs[i].name), rsp_data, vecs[i].rsp);
    end

    // Clamp to 1 then a back-to-back clamp to MAX_LEN accepted in the rsp cycle
    run_cmd("b2b_len0", 2'b10, 6'd0, 32'hFFFF_FFFF, 1, 6, 32'h0, 1'b0);
    run_cmd("b2b_len40", 2'b10, 6'd40, 32'h1234_5678, 32, 37, 32'h2468_ACF0, 1'b0);
    @(posedge TCK); #1;
    check("b2b rsp_valid drop", rsp_valid, 0);

    // Inputs toggled while busy must not disturb the scan
    run_cmd("dr16_noise", 2'b10, 6'd16, 32'h0000_BEEF, 16, 21, 32'h0000_7DDE, 1'b1);
    @(posedge TCK); #1;
    check("noise idle", {busy, cmd_ready, rsp_valid}, 3'b010);

    // Reset during shift bit 3 of a 16-bit DR scan
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 6'd16;
    cmd_data  = 32'h0000_FFFF;
    @(posedge TCK); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge TCK);
    #1;
    check("abort pre tms (shift bit3)", TMS, 0);
    check("abort pre tdi (shift bit3)", TDI, 1);
    TRST_N = 1'b0;
    #1;
    check("abort tms/tdi", {TMS, TDI}, 2'b10);
    check("abort busy/ready/rsp", {busy, cmd_ready, rsp_valid}, 3'b100);
    check("abort rsp_data", rsp_data, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge TCK); #1;
      check($sformatf("abort hold rsp c=%0d", c), {rsp_valid, TMS}, 2'b01);
    end
    init_walk("reinit");
    run_cmd("post_reset_dr4", 2'b10, 6'd4, 32'h0000_0006, 4, 9, 32'h0000_000C, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
